// File: rtl/special_request_arbiter_if.sv
// Request/grant bundle between roadside detectors and the preemption arbiter.
interface special_request_arbiter_if #(
  parameter int N_REQ = 4
);
  // Req is a level held while a vehicle is present; it is not latched, so a
  // requester is only considered if Req is still high when the arbiter is idle.
  // Grant is the registered acknowledgement and stays high for the whole grant.
  logic [N_REQ-1:0] Req;
  logic [N_REQ-1:0] Req_Dir;
  logic [N_REQ-1:0] Grant;
  logic             Main_Special;
  logic             Side_Special;
  logic             Busy;
  logic             Timeout;

  modport master (
    output Req, Req_Dir,
    input  Grant, Main_Special, Side_Special, Busy, Timeout
  );

  modport slave (
    input  Req, Req_Dir,
    output Grant, Main_Special, Side_Special, Busy, Timeout
  );
endinterface

// File: rtl/special_request_arbiter.sv
// Round-robin arbiter for emergency-vehicle preemption with hold dwell and cooldown.
// Optional grant cap with Timeout pulse is enabled by defining ARB_TIMEOUT_EN.
module special_request_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int PULSE_CYCLES = 2,
  parameter int COOL_CYCLES  = 8,
  parameter int MAX_GRANT    = 64
) (
  input  logic                      Clk,
  input  logic                      Rst,
  special_request_arbiter_if.slave  bus,
  output logic [1:0]                dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] COOL  = 2'd2;

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
  localparam int COOL_W  = $clog2(COOL_CYCLES + 1);

  logic [1:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   next_ptr;
  logic               sel_valid;
  logic               dir;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [COOL_W-1:0]  cool_cnt;
  logic [N_REQ-1:0]   one_hot_base;
  logic               req_cur;
  logic               cap_hit;
  logic               end_grant;

  assign dbg_state    = state;
  assign one_hot_base = {{(N_REQ-1){1'b0}}, 1'b1};
  assign req_cur      = bus.Req[gnt_idx];

  // First asserted request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = IDX_W'((int'(rr_ptr) + j) % N_REQ);
      if (!sel_valid && bus.Req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign next_ptr = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int GC_W = $clog2(MAX_GRANT + 1);
  logic [GC_W-1:0] grant_cnt;

  // grant_cnt holds the number of cycles the current grant has been visible.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      grant_cnt <= '0;
    end else if (state == IDLE && sel_valid) begin
      grant_cnt <= GC_W'(1);
    end else if (state == GRANT && grant_cnt != GC_W'(MAX_GRANT)) begin
      grant_cnt <= grant_cnt + 1'b1;
    end
  end

  assign cap_hit = (grant_cnt == GC_W'(MAX_GRANT));
`else
  assign cap_hit = 1'b0;
`endif

  assign end_grant = ((hold_cnt == '0) && !req_cur) || cap_hit;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      gnt_idx          <= '0;
      dir              <= 1'b0;
      hold_cnt         <= '0;
      pulse_cnt        <= '0;
      cool_cnt         <= '0;
      bus.Grant        <= '0;
      bus.Main_Special <= 1'b0;
      bus.Side_Special <= 1'b0;
      bus.Busy         <= 1'b0;
      bus.Timeout      <= 1'b0;
    end else begin
      bus.Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state            <= GRANT;
            gnt_idx          <= sel_idx;
            bus.Grant        <= one_hot_base << sel_idx;
            dir              <= bus.Req_Dir[sel_idx];
            bus.Main_Special <= ~bus.Req_Dir[sel_idx];
            bus.Side_Special <= bus.Req_Dir[sel_idx];
            hold_cnt         <= HOLD_W'(HOLD_CYCLES - 1);
            pulse_cnt        <= PULSE_W'(PULSE_CYCLES - 1);
            rr_ptr           <= next_ptr;
            bus.Busy         <= 1'b1;
          end
        end
        GRANT: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          // Direction was latched at the grant edge; Req_Dir is not consulted here.
          if (pulse_cnt != '0) begin
            pulse_cnt        <= pulse_cnt - 1'b1;
            bus.Main_Special <= ~dir;
            bus.Side_Special <= dir;
          end else begin
            bus.Main_Special <= 1'b0;
            bus.Side_Special <= 1'b0;
          end
          if (end_grant) begin
            state            <= COOL;
            bus.Grant        <= '0;
            bus.Main_Special <= 1'b0;
            bus.Side_Special <= 1'b0;
            cool_cnt         <= COOL_W'(COOL_CYCLES - 1);
            bus.Timeout      <= cap_hit && req_cur;
          end
        end
        COOL: begin
          if (cool_cnt == '0) begin
            state    <= IDLE;
            bus.Busy <= 1'b0;
          end else begin
            cool_cnt <= cool_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.Grant <= '0;
          bus.Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_special_request_arbiter.sv
// Bench for special_request_arbiter: vector table, directed corner sequences,
// and random traffic compared against a cycle-count reference model.
module tb_special_request_arbiter;

  localparam int N     = 4;
  localparam int HOLD  = 16;
  localparam int PULSE = 2;
  localparam int COOL  = 8;
  localparam int MAXG  = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  special_request_arbiter_if #(.N_REQ(N)) bus();

  special_request_arbiter #(
    .N_REQ(N), .HOLD_CYCLES(HOLD), .PULSE_CYCLES(PULSE),
    .COOL_CYCLES(COOL), .MAX_GRANT(MAXG)
  ) dut (
    .Clk(clk), .Rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index, how many cycles the grant has been visible,
  // how many cooldown cycles have elapsed, and the round-robin start point.
  int   m_owner = -1;
  int   m_age   = 0;
  int   m_cool  = -1;
  int   m_ptr   = 0;
  logic m_dir   = 1'b0;
  logic m_to    = 1'b0;

  task automatic model_edge(input logic r, input logic [3:0] q, input logic [3:0] d);
    bit capped;
    bit found;
    int c;
    capped = 0;
    found  = 0;
    m_to   = 1'b0;
    if (r) begin
      m_owner = -1; m_cool = -1; m_ptr = 0; m_age = 0;
    end else if (m_owner >= 0) begin
`ifdef ARB_TIMEOUT_EN
      capped = (m_age >= MAXG);
`endif
      if ((m_age >= HOLD && !q[m_owner]) || capped) begin
        m_to    = capped && q[m_owner];
        m_owner = -1;
        m_cool  = 0;
      end else begin
        m_age++;
      end
    end else if (m_cool >= 0) begin
      m_cool++;
      if (m_cool == COOL) m_cool = -1;
    end else if (q != 4'b0000) begin
      for (int j = 0; j < N; j++) begin
        c = (m_ptr + j) % N;
        if (!found && q[c]) begin
          found   = 1;
          m_owner = c;
        end
      end
      m_age = 1;
      m_dir = d[m_owner];
      m_ptr = (m_owner + 1) % N;
    end
  endtask

  // driver: apply inputs at negedge, advance model at posedge, compare 1 time unit later
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] d);
    logic [3:0] one;
    logic [3:0] eg;
    logic       pulse;
    logic       busy;
    @(negedge clk);
    rst = r; bus.Req = q; bus.Req_Dir = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    one   = 4'b0001;
    eg    = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
    pulse = (m_owner >= 0) && (m_age <= PULSE);
    busy  = (m_owner >= 0) || (m_cool >= 0);
    check("model_grant", bus.Grant, eg);
    check("model_flags", {bus.Main_Special, bus.Side_Special, bus.Busy, bus.Timeout},
          {pulse & ~m_dir, pulse & m_dir, busy, m_to});
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_owner >= 0 || m_cool >= 0); i++) step(1'b0, 4'b0000, 4'b0000);
    check("drain_idle", {bus.Busy, bus.Grant}, 5'b0);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] dir;
    int         reps;
    logic [3:0] grant;
    logic       main_s;
    logic       side_s;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  logic [3:0] side_q[$];

  initial begin
    int   gcyc;
    int   pcyc;
    int   nz;
    int   tos;
    int   starts;
    logic [3:0] prev;
    logic [3:0] q;
    logic [3:0] rr_req;

    rst = 1'b1; bus.Req = '0; bus.Req_Dir = '0;

    // single main-road request, then a side-road request
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 3,  4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 2,  4'b0010, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 1,  4'b0010, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 13, 4'b0010, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 8,  4'b0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3,  4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1000, 4'b1000, 2,  4'b1000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b1111, 14, 4'b1000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 8,  4'b0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2,  4'b0000, 1'b0, 1'b0, 1'b0});

    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].reps; r++) begin
        step(tbl[k].rst, tbl[k].req, tbl[k].dir);
        check("tbl_grant", bus.Grant, tbl[k].grant);
        check("tbl_flags", {bus.Main_Special, bus.Side_Special, bus.Busy},
              {tbl[k].main_s, tbl[k].side_s, tbl[k].busy});
      end
    end

    // round robin between requesters 0 and 3; the owner releases once granted
    exp_q = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    prev  = 4'b0000;
    for (int i = 0; i < 300 && got_q.size() < 4; i++) begin
      rr_req = (m_owner >= 0) ? (4'b1001 & ~(4'b0001 << m_owner)) : 4'b1001;
      step(1'b0, rr_req, 4'b1000);
      if (prev == 4'b0000 && bus.Grant != 4'b0000) begin
        got_q.push_back(bus.Grant);
        side_q.push_back({3'b000, bus.Side_Special});
      end
      prev = bus.Grant;
    end
    check("rr_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check("rr_order", got_q[i], exp_q[i]);
      check("rr_side", side_q[i], {3'b000, exp_q[i][3]});
    end
    drain();

    // one request held 30 cycles: grant covers all of them, one pulse only
    gcyc = 0; pcyc = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'b0100, (i > 0) ? 4'b0100 : 4'b0000);
      if (bus.Grant == 4'b0100) gcyc++;
      if (bus.Main_Special || bus.Side_Special) pcyc++;
    end
    for (int i = 0; i < 5 && bus.Grant != 4'b0000; i++) step(1'b0, 4'b0000, 4'b0000);
    check("hold30_grant_cycles", gcyc, 30);
    check("hold30_pulse_cycles", pcyc, PULSE);
    check("hold30_released", bus.Grant, 4'b0000);
    drain();

    // reset five cycles into a grant, then all requesters compete
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0100, 4'b0000);
    step(1'b1, 4'b1111, 4'b1111);
    check("rst_outputs", {bus.Grant, bus.Main_Special, bus.Side_Special, bus.Busy, bus.Timeout}, 9'b0);
    step(1'b0, 4'b1111, 4'b0000);
    check("rst_rr_ptr", bus.Grant, 4'b0001);
    step(1'b0, 4'b0000, 4'b0000);

    // one-cycle request during cooldown is never granted
    for (int i = 0; i < 40 && m_cool < 0; i++) step(1'b0, 4'b0000, 4'b0000);
    check("cool_reached", bus.Busy && bus.Grant == 4'b0000, 1);
    step(1'b0, 4'b0010, 4'b0000);
    nz = 0;
    for (int i = 0; i < COOL + 4; i++) begin
      step(1'b0, 4'b0000, 4'b0000);
      if (bus.Grant != 4'b0000) nz++;
    end
    check("cool_pulse_dropped", nz, 0);
    drain();

    // long request: capped and re-granted with the cap, held throughout without it
    tos = 0; starts = 0; prev = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 4'b0100, 4'b0000);
      if (bus.Timeout) tos++;
      if (prev == 4'b0000 && bus.Grant == 4'b0100) starts++;
      prev = bus.Grant;
    end
`ifdef ARB_TIMEOUT_EN
    check("long_timeouts", tos, 2);
    check("long_regrants", starts, 3);
`else
    check("long_timeouts", tos, 0);
    check("long_regrants", starts, 1);
`endif
    drain();

    // random traffic
    q = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) q = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 149) == 0), q, 4'($urandom_range(0, 15)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
